// File: rtl/axi_master_wr_engine_if.sv
// axi_master_wr_engine_if: AXI4 write-channel bundle (AW, W, B) between the engine and a slave
interface axi_master_wr_engine_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY
  );
  modport slave (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY
  );
endinterface

// File: rtl/axi_master_wr_engine.sv
// axi_master_wr_engine: AXI4 write master with decoupled AW/W channels and up to MAX_OUTST outstanding bursts
module axi_master_wr_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                  AClk,
  input  logic                  ARst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  axi_master_wr_engine_if.master axi,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [1:0]            rsp_resp,
  output logic [4:0]            outst_cnt,
  output logic                  err_unexp
);
  localparam int PW = $clog2(MAX_OUTST);
  typedef enum logic {AW_IDLE, AW_VALID} aw_state_t;
  typedef enum logic {W_IDLE, W_DATA} w_state_t;
  aw_state_t aw_state, aw_next;
  w_state_t  w_state, w_next;
  logic [7:0]  lens [MAX_OUTST];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic [7:0]  cur_len, beat_cnt;
  logic cmd_acc, b_hs, w_hs, w_load, fifo_rd, fifo_wr, fifo_empty, fifo_full;
  always_comb begin
    fifo_empty   = fifo_cnt == '0;
    fifo_full    = fifo_cnt == (PW+1)'(MAX_OUTST);
    cmd_ready    = ARst & aw_state == AW_IDLE & outst_cnt < 5'(MAX_OUTST) & !fifo_full;
    cmd_acc      = cmd_valid & cmd_ready;
    b_hs         = axi.BVALID & axi.BREADY;
    axi.AWVALID  = aw_state == AW_VALID;
    axi.WVALID   = w_state == W_DATA & wd_valid;
    wd_ready     = w_state == W_DATA & axi.WREADY;
    axi.WDATA    = wd_data;
    axi.WSTRB    = wd_strb;
    axi.WLAST    = w_state == W_DATA & beat_cnt == cur_len;
    w_hs         = axi.WVALID & axi.WREADY;
    // An empty FIFO is bypassed so the first beat can go out alongside AWVALID
    w_load       = w_state == W_IDLE & (!fifo_empty | cmd_acc);
    fifo_rd      = w_load & !fifo_empty;
    fifo_wr      = cmd_acc & !(w_load & fifo_empty);
    aw_next      = aw_state == AW_IDLE ? (cmd_acc ? AW_VALID : AW_IDLE) : (axi.AWREADY ? AW_IDLE : AW_VALID);
    w_next       = w_state == W_IDLE ? (w_load ? W_DATA : W_IDLE) : (w_hs & axi.WLAST ? W_IDLE : W_DATA);
  end
  always_ff @(posedge AClk) begin
    if (!ARst) begin
      aw_state    <= AW_IDLE;
      w_state     <= W_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      cur_len     <= '0;
      beat_cnt    <= '0;
      axi.AWID    <= '0;
      axi.AWADDR  <= '0;
      axi.AWLEN   <= '0;
      axi.AWSIZE  <= '0;
      axi.AWBURST <= '0;
      axi.BREADY  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_resp    <= '0;
      outst_cnt   <= '0;
      err_unexp   <= 1'b0;
    end else begin
      aw_state   <= aw_next;
      w_state    <= w_next;
      axi.BREADY <= 1'b1;
      if (cmd_acc) begin
        axi.AWID    <= cmd_id;
        axi.AWADDR  <= cmd_addr;
        axi.AWLEN   <= cmd_len;
        axi.AWSIZE  <= cmd_size;
        axi.AWBURST <= cmd_burst;
      end
      if (fifo_wr) begin
        lens[wr_ptr] <= cmd_len;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (PW+1)'(fifo_wr) - (PW+1)'(fifo_rd);
      if (w_load) begin
        cur_len  <= fifo_empty ? cmd_len : lens[rd_ptr];
        beat_cnt <= '0;
      end else if (w_hs) beat_cnt <= beat_cnt + 1'b1;
      // A response with nothing outstanding is flagged rather than letting the count wrap
      outst_cnt <= outst_cnt + 5'(cmd_acc) - 5'(b_hs & outst_cnt != 5'd0);
      rsp_valid <= b_hs;
      if (b_hs) begin
        rsp_id   <= axi.BID;
        rsp_resp <= axi.BRESP;
      end
      if (b_hs & outst_cnt == 5'd0) err_unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_master_wr_engine.sv
// tb_axi_master_wr_engine: scoreboard bench for the AXI write engine (AW payloads, W beats, responses)
module tb_axi_master_wr_engine;
  localparam int DW = 64;
  localparam int SW = 8;
  logic AClk = 1'b0;
  logic ARst;
  logic cmd_valid, cmd_ready;
  logic [7:0] cmd_id, cmd_len;
  logic [31:0] cmd_addr;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [SW-1:0] wd_strb;
  logic rsp_valid, err_unexp;
  logic [7:0] rsp_id;
  logic [1:0] rsp_resp;
  logic [4:0] outst_cnt;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW+SW-1:0] wd_q[$];
  logic [DW+SW:0] w_exp[$];
  logic [7+32+8+3+2:0] aw_exp[$];
  logic [9:0] rsp_exp[$];
  logic wd_took = 1'b0;

  axi_master_wr_engine_if #(.ID_W(8), .ADDR_W(32), .DATA_W(DW)) ifc();

  axi_master_wr_engine #(.ADDR_W(32), .DATA_W(DW), .ID_W(8), .MAX_OUTST(4)) dut (
    .AClk(AClk), .ARst(ARst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .axi(ifc),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .outst_cnt(outst_cnt), .err_unexp(err_unexp)
  );

  always #5 AClk = ~AClk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  task automatic push_beats(input logic [7:0] id, input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++) begin
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      d = {id, 8'(b), 16'h0, 32'($urandom)};
      s = 8'($urandom);
      wd_q.push_back({d, s});
      w_exp.push_back({d, s, 1'(b == int'(len))});
    end
  endtask

  task automatic send_cmd(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic ok;
    tick();
    push_beats(id, len);
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = 3'd3; cmd_burst = 2'd1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge AClk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1'b1);
    if (ok) aw_exp.push_back({id, addr, len, 3'd3, 2'd1});
  endtask

  task automatic send_b(input logic [7:0] id, input logic [1:0] resp);
    logic ok;
    tick();
    ifc.BVALID = 1'b1; ifc.BID = id; ifc.BRESP = resp;
    rsp_exp.push_back({id, resp});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge AClk);
      ok = ifc.BREADY;
      tick();
    end
    ifc.BVALID = 1'b0;
    check("b_accepted", ok, 1'b1);
  endtask

  task automatic do_reset(input int n);
    tick();
    cmd_valid = 1'b0;
    ifc.BVALID = 1'b0;
    ARst = 1'b0;
    @(negedge AClk);
    tick();
    wd_q.delete(); w_exp.delete(); aw_exp.delete(); rsp_exp.delete();
    repeat (n - 1) tick();
    ARst = 1'b1;
  endtask

  // Decoder model: present the head beat, retire it once the engine consumed it
  always @(posedge AClk) begin
    #2;
    if (wd_took && wd_q.size() != 0) void'(wd_q.pop_front());
    wd_valid = wd_q.size() != 0;
    if (wd_valid) {wd_data, wd_strb} = wd_q[0];
  end

  always @(negedge AClk) begin
    wd_took = wd_valid & wd_ready;
    if (ifc.WVALID & ifc.WREADY) begin
      check("w_expected", w_exp.size() != 0, 1'b1);
      if (w_exp.size() != 0) begin
        logic [DW+SW:0] e;
        e = w_exp.pop_front();
        check("wdata", ifc.WDATA, e[DW+SW:SW+1]);
        check("wstrb", ifc.WSTRB, e[SW:1]);
        check("wlast", ifc.WLAST, e[0]);
      end
    end
    if (ifc.AWVALID & ifc.AWREADY) begin
      check("aw_expected", aw_exp.size() != 0, 1'b1);
      if (aw_exp.size() != 0) begin
        logic [7+32+8+3+2:0] a;
        a = aw_exp.pop_front();
        check("awid", ifc.AWID, a[52:45]);
        check("awaddr", ifc.AWADDR, a[44:13]);
        check("awlen", ifc.AWLEN, a[12:5]);
        check("awsize", ifc.AWSIZE, a[4:2]);
        check("awburst", ifc.AWBURST, a[1:0]);
      end
    end
    if (rsp_valid) begin
      check("rsp_expected", rsp_exp.size() != 0, 1'b1);
      if (rsp_exp.size() != 0) begin
        logic [9:0] r;
        r = rsp_exp.pop_front();
        check("rsp_id", rsp_id, r[9:2]);
        check("rsp_resp", rsp_resp, r[1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ARst = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
    ifc.AWREADY = 1'b1; ifc.WREADY = 1'b1; ifc.BVALID = 1'b0; ifc.BID = '0; ifc.BRESP = '0;
    repeat (3) tick();
    @(negedge AClk);
    check("rst_awvalid", ifc.AWVALID, 1'b0);
    check("rst_wvalid", ifc.WVALID, 1'b0);
    check("rst_bready", ifc.BREADY, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_outst", outst_cnt, 5'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_err", err_unexp, 1'b0);
    check("rst_awaddr", ifc.AWADDR, 32'd0);
    tick();
    ARst = 1'b1;
    @(negedge AClk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    tick();
    @(negedge AClk);
    check("post_rst_bready", ifc.BREADY, 1'b1);

    // single burst
    send_cmd(8'd3, 32'h1000, 8'd3);
    @(negedge AClk);
    check("single_awvalid_n1", ifc.AWVALID, 1'b1);
    check("single_wvalid_n1", ifc.WVALID, 1'b1);
    check("single_wlast_b1", ifc.WLAST, 1'b0);
    check("single_outst", outst_cnt, 5'd1);
    for (int b = 2; b <= 4; b++) begin
      @(negedge AClk);
      check("single_wlast_b", ifc.WLAST, 1'(b == 4));
    end
    @(negedge AClk);
    check("single_w_idle", ifc.WVALID, 1'b0);
    send_b(8'd3, 2'd0);
    @(negedge AClk);
    check("single_rsp_pulse", rsp_valid, 1'b1);
    check("single_outst_done", outst_cnt, 5'd0);

    // outstanding limit
    for (int i = 0; i < 4; i++) send_cmd(8'(10 + i), 32'h100 * i, 8'd0);
    @(negedge AClk);
    check("outst_full_cnt", outst_cnt, 5'd4);
    tick();
    push_beats(8'd14, 8'd0);
    cmd_valid = 1'b1; cmd_id = 8'd14; cmd_addr = 32'h400; cmd_len = 8'd0; cmd_size = 3'd3; cmd_burst = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge AClk);
      check("outst_block", cmd_ready, 1'b0);
      tick();
    end
    send_b(8'd10, 2'd0);
    @(negedge AClk);
    check("outst_unblock", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    aw_exp.push_back({8'd14, 32'h400, 8'd0, 3'd3, 2'd1});
    @(negedge AClk);
    check("outst_refill", outst_cnt, 5'd4);
    for (int i = 0; i < 4; i++) send_b(8'(11 + i), 2'(i + 1));
    @(negedge AClk);
    check("outst_drained", outst_cnt, 5'd0);

    // AW stall while W proceeds
    tick();
    ifc.AWREADY = 1'b0;
    send_cmd(8'h21, 32'h2000, 8'd3);
    for (int i = 0; i < 6; i++) begin
      @(negedge AClk);
      check("stall_awvalid", ifc.AWVALID, 1'b1);
      check("stall_awaddr", ifc.AWADDR, 32'h2000);
      check("stall_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    check("stall_w_done", w_exp.size(), 0);
    ifc.AWREADY = 1'b1;
    @(negedge AClk);
    tick();
    @(negedge AClk);
    check("stall_cmd_ready_after", cmd_ready, 1'b1);
    send_b(8'h21, 2'd0);

    // simultaneous accept and response
    send_cmd(8'h30, 32'h3000, 8'd0);
    send_cmd(8'h31, 32'h3100, 8'd0);
    tick();
    push_beats(8'h32, 8'd0);
    cmd_valid = 1'b1; cmd_id = 8'h32; cmd_addr = 32'h3200; cmd_len = 8'd0; cmd_size = 3'd3; cmd_burst = 2'd1;
    ifc.BVALID = 1'b1; ifc.BID = 8'h30; ifc.BRESP = 2'd0;
    rsp_exp.push_back({8'h30, 2'd0});
    @(negedge AClk);
    check("simul_cmd_ready", cmd_ready, 1'b1);
    check("simul_outst_before", outst_cnt, 5'd2);
    tick();
    cmd_valid = 1'b0;
    ifc.BVALID = 1'b0;
    aw_exp.push_back({8'h32, 32'h3200, 8'd0, 3'd3, 2'd1});
    @(negedge AClk);
    check("simul_outst_after", outst_cnt, 5'd2);
    send_b(8'h31, 2'd0);
    send_b(8'h32, 2'd1);
    @(negedge AClk);
    check("simul_drained", outst_cnt, 5'd0);

    // unexpected response
    do_reset(2);
    tick();
    send_b(8'h55, 2'd2);
    @(negedge AClk);
    check("unexp_rsp_pulse", rsp_valid, 1'b1);
    check("unexp_err", err_unexp, 1'b1);
    check("unexp_outst", outst_cnt, 5'd0);
    tick();
    @(negedge AClk);
    check("unexp_err_sticky", err_unexp, 1'b1);
    do_reset(2);
    @(negedge AClk);
    check("unexp_err_cleared", err_unexp, 1'b0);

    // reset mid-burst
    send_cmd(8'h40, 32'h4000, 8'd7);
    tick();
    ARst = 1'b0;
    @(negedge AClk);
    tick();
    wd_q.delete(); w_exp.delete(); aw_exp.delete(); rsp_exp.delete();
    @(negedge AClk);
    check("midrst_awvalid", ifc.AWVALID, 1'b0);
    check("midrst_wvalid", ifc.WVALID, 1'b0);
    check("midrst_outst", outst_cnt, 5'd0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    tick();
    ARst = 1'b1;
    @(negedge AClk);
    check("midrst_cmd_ready_release", cmd_ready, 1'b1);

    repeat (3) tick();
    check("sb_w_empty", w_exp.size(), 0);
    check("sb_aw_empty", aw_exp.size(), 0);
    check("sb_rsp_empty", rsp_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
